mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one single-port word memory between two requesters: master 0 (MEM-stage access controller) and master 1 (instruction fetch).
- Grants ownership round-robin, holds the grant until the owner releases its request, and muxes the owner's address, control and write data onto the memory side.
- Returns read data and the wait-state acknowledge to the owner only.
- Sits between the pipeline memory-access logic and the memory/bus slave.

Parameters:
- TIMEOUT_CYC, 16, cycles an owner may wait for s_rdy_ before a forced abort (used only with the optional feature; legal range 2..255).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous reset, active-high
- m0_req_  in  1  master 0 bus request, active-low
- m0_grnt_  out  1  master 0 grant, active-low
- m0_as_  in  1  master 0 address strobe, active-low
- m0_rw  in  1  master 0 direction: READ=1, WRITE=0
- m0_addr  in  30  master 0 word address
- m0_wr_data  in  32  master 0 write data
- m0_rd_data  out  32  read data to master 0
- m0_rdy_  out  1  access complete to master 0, active-low
- m1_req_, m1_grnt_, m1_as_, m1_rw, m1_addr, m1_wr_data, m1_rd_data, m1_rdy_  same as m0_*, for master 1
- s_as_  out  1  memory address strobe, active-low
- s_rw  out  1  memory direction
- s_addr  out  30  memory word address
- s_wr_data  out  32  memory write data
- s_rd_data  in  32  memory read data
- s_rdy_  in  1  memory ready, active-low
- bus_err  out  1  one-cycle pulse on timeout abort; tied 0 without the optional feature

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- States: IDLE, OWN0, OWN1. A 1-bit last_owner register drives round-robin.
- Reset values: state=IDLE, last_owner=1 (master 0 wins the first tie), both grnt_=1, s_as_=1, s_rw=READ, s_addr=0, s_wr_data=0, both m*_rdy_=1, both m*_rd_data=0, bus_err=0, timeout counter=0.
- IDLE transitions:
  - Only m0_req_=0 -> OWN0.
  - Only m1_req_=0 -> OWN1.
  - Both requesting -> OWNx where x != last_owner.
  - On entry to OWNx, set last_owner=x.
- Grant latency: grnt_ is registered, so it asserts 1 cycle after the req_ falling edge seen in IDLE.
- OWNx, owner holding req_=0: stay in OWNx. Grant is never pre-empted.
- OWNx, owner releasing req_=1:
  - Other master requesting -> OWNy directly, no IDLE bubble; grant switches next cycle.
  - Otherwise -> IDLE.
- Mux (combinational from state):
  - In OWNx: s_as_/s_rw/s_addr/s_wr_data = mx_*; mx_rd_data = s_rd_data; mx_rdy_ = s_rdy_.
  - Non-owner: rdy_=1, rd_data=0.
  - In IDLE: s_as_=1, s_rw=READ, s_addr=0, s_wr_data=0.
- Masters assert as_ only while granted. An as_ from a non-owner is ignored and never reaches s_as_.
- Owner releasing req_ while its access is pending (as_=0, s_rdy_=1) is illegal. Behaviour: the grant is dropped and the access is abandoned.
- Reset mid-access: the next cycle is IDLE, s_as_=1, and the pending access is dropped.

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- Enabled: an 8-bit counter increments each cycle that s_as_=0 and s_rdy_=1, and clears on s_rdy_=0, on an owner change, or in IDLE. When the counter reaches TIMEOUT_CYC-1:
  - the owner's rdy_ is forced to 0 for one cycle with rd_data=0;
  - bus_err pulses 1 in the same cycle;
  - the counter clears.
- Disabled: no counter, the owner waits indefinitely, bus_err is constant 0.

Decomposition:
- Shared package/defines hold:
  - ENABLE_/DISABLE_ and READ/WRITE constants
  - WORD_ADDR_W=30, WORD_DATA_W=32
  - state encoding IDLE=2'd0, OWN0=2'd1, OWN1=2'd2
- One sub-module is natural: mem_bus_rr_arb, which is pure next-state/grant logic from (state, last_owner, req_ vector). The data mux stays in the top level.

Test Plan:
- Reset, then m0_req_=0 at cycle 2 -> m0_grnt_=0 at cycle 3. m0 read of addr 0x0000010 with s_rdy_=0 after 2 wait cycles -> m0_rdy_=0 and m0_rd_data=s_rd_data (0xDEADBEEF); m1_rdy_ stays 1.
- m0_req_ and m1_req_ fall in the same cycle after reset -> m0 granted first. m0 releases -> m1_grnt_=0 the next cycle, with no IDLE cycle between.
- Both masters hold requests continuously, each releasing after one access -> grants alternate 0,1,0,1 over 8 accesses.
- m1 owns the bus; m0 asserts m0_as_=0 with addr 0x3 and WRITE -> s_as_, s_addr and s_rw follow m1 only; no write to 0x3 occurs.
- reset=1 while the owner's as_=0 and s_rdy_=1 -> next cycle state=IDLE, s_as_=1, both grnt_=1.
- MEM_BUS_TIMEOUT_EN, TIMEOUT_CYC=16, s_rdy_ held 1 -> at the 16th wait cycle the owner's rdy_=0 and bus_err=1 for exactly 1 cycle, rd_data=0. Without the macro -> rdy_ stays 1 and bus_err stays 0 for 100 cycles.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
// Shared constants for the two-master memory bus arbiter:
//   - active-low strobe levels (ENABLE_/DISABLE_)
//   - bus direction encoding (READ/WRITE)
//   - word address / data widths
//   - arbiter state encoding
package mem_bus_arbiter_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_bus_rr_arb.sv
// mem_bus_rr_arb
// Pure combinational next-state logic for the round-robin bus arbiter.
// Ports:
//   state           in   current arbiter state
//   last_owner      in   master that most recently received the bus
//   req_            in   active-low request vector, bit 0 = master 0
//   next_state      out  state for the next cycle
//   next_last_owner out  updated round-robin pointer
module mem_bus_rr_arb
    import mem_bus_arbiter_pkg::*;
(
    input  arb_state_e state,
    input  logic       last_owner,
    input  logic [1:0] req_,
    output arb_state_e next_state,
    output logic       next_last_owner
);

    logic want0;
    logic want1;

    assign want0 = (req_[0] == ENABLE_);
    assign want1 = (req_[1] == ENABLE_);

    always_comb begin
        next_state      = state;
        next_last_owner = last_owner;

        case (state)
            IDLE: begin
                if (want0 && want1) begin
                    // Tie goes to whichever master did not own the bus last.
                    next_state = last_owner ? OWN0 : OWN1;
                end else if (want0) begin
                    next_state = OWN0;
                end else if (want1) begin
                    next_state = OWN1;
                end else begin
                    next_state = IDLE;
                end
            end
            OWN0: begin
                // Ownership is never pre-empted; hand over only on release.
                if (!want0) begin
                    next_state = want1 ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!want1) begin
                    next_state = want0 ? OWN0 : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        if (next_state == OWN0 && state != OWN0) begin
            next_last_owner = 1'b0;
        end else if (next_state == OWN1 && state != OWN1) begin
            next_last_owner = 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one single-port word memory between master 0 (MEM-stage access)
// and master 1 (instruction fetch). Round-robin ownership, held until the
// owner releases its request; the owner's address/control/write data are
// muxed onto the memory side and read data / ready go back to the owner only.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   mN_req_/mN_grnt_            per-master request in / registered grant out
//   mN_as_/mN_rw/mN_addr/       per-master strobe, direction, word address,
//   mN_wr_data                  write data
//   mN_rd_data/mN_rdy_          per-master read data and ready out
//   s_as_/s_rw/s_addr/s_wr_data memory-side strobe, direction, address, data
//   s_rd_data/s_rdy_            memory read data and ready in
//   bus_err                     one-cycle pulse on a timeout abort
// Optional feature: define MEM_BUS_TIMEOUT_EN to abort an access that waits
// TIMEOUT_CYC cycles for s_rdy_; otherwise bus_err is tied low.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
)
(
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   m0_req_,
    output logic                   m0_grnt_,
    input  logic                   m0_as_,
    input  logic                   m0_rw,
    input  logic [WORD_ADDR_W-1:0] m0_addr,
    input  logic [WORD_DATA_W-1:0] m0_wr_data,
    output logic [WORD_DATA_W-1:0] m0_rd_data,
    output logic                   m0_rdy_,

    input  logic                   m1_req_,
    output logic                   m1_grnt_,
    input  logic                   m1_as_,
    input  logic                   m1_rw,
    input  logic [WORD_ADDR_W-1:0] m1_addr,
    input  logic [WORD_DATA_W-1:0] m1_wr_data,
    output logic [WORD_DATA_W-1:0] m1_rd_data,
    output logic                   m1_rdy_,

    output logic                   s_as_,
    output logic                   s_rw,
    output logic [WORD_ADDR_W-1:0] s_addr,
    output logic [WORD_DATA_W-1:0] s_wr_data,
    input  logic [WORD_DATA_W-1:0] s_rd_data,
    input  logic                   s_rdy_,

    output logic                   bus_err
);

    arb_state_e state;
    arb_state_e next_state;
    logic       last_owner;
    logic       next_last_owner;
    logic       timeout_fire;

    mem_bus_rr_arb u_rr_arb (
        .state           (state),
        .last_owner      (last_owner),
        .req_            ({m1_req_, m0_req_}),
        .next_state      (next_state),
        .next_last_owner (next_last_owner)
    );

    // Grants are registered from the next state so they line up with the
    // state register: a request seen in IDLE is granted one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            m0_grnt_   <= DISABLE_;
            m1_grnt_   <= DISABLE_;
        end else begin
            state      <= next_state;
            last_owner <= next_last_owner;
            m0_grnt_   <= (next_state == OWN0) ? ENABLE_ : DISABLE_;
            m1_grnt_   <= (next_state == OWN1) ? ENABLE_ : DISABLE_;
        end
    end

`ifdef MEM_BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] timeout_cnt;

    assign timeout_fire = (state != IDLE) && (s_as_ == ENABLE_) &&
                          (s_rdy_ == DISABLE_) && (timeout_cnt == TIMEOUT_LAST);
    assign bus_err      = timeout_fire;

    // Counts wait cycles of the current access; any completion, owner
    // change, idle cycle or abort starts the count over.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_cnt <= 8'd0;
        end else if (state == IDLE || s_rdy_ == ENABLE_ ||
                     next_state != state || timeout_fire) begin
            timeout_cnt <= 8'd0;
        end else if (s_as_ == ENABLE_) begin
            timeout_cnt <= timeout_cnt + 8'd1;
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign bus_err      = 1'b0;
`endif

    // Memory-side mux: only the owner's signals reach the memory, so a
    // strobe from the non-owner can never start an access.
    always_comb begin
        s_as_     = DISABLE_;
        s_rw      = READ;
        s_addr    = '0;
        s_wr_data = '0;
        case (state)
            OWN0: begin
                s_as_     = m0_as_;
                s_rw      = m0_rw;
                s_addr    = m0_addr;
                s_wr_data = m0_wr_data;
            end
            OWN1: begin
                s_as_     = m1_as_;
                s_rw      = m1_rw;
                s_addr    = m1_addr;
                s_wr_data = m1_wr_data;
            end
            default: ;
        endcase
    end

    // Return path: kept separate from the memory-side mux because the abort
    // term depends on s_as_.
    always_comb begin
        m0_rdy_    = DISABLE_;
        m0_rd_data = '0;
        m1_rdy_    = DISABLE_;
        m1_rd_data = '0;
        if (state == OWN0) begin
            m0_rdy_    = timeout_fire ? ENABLE_ : s_rdy_;
            m0_rd_data = timeout_fire ? '0 : s_rd_data;
        end else if (state == OWN1) begin
            m1_rdy_    = timeout_fire ? ENABLE_ : s_rdy_;
            m1_rd_data = timeout_fire ? '0 : s_rd_data;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int TIMEOUT_CYC = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req_ = 1'b1, m0_as_ = 1'b1, m0_rw = 1'b1;
    logic [29:0] m0_addr = '0;
    logic [31:0] m0_wr_data = '0;
    logic        m1_req_ = 1'b1, m1_as_ = 1'b1, m1_rw = 1'b1;
    logic [29:0] m1_addr = '0;
    logic [31:0] m1_wr_data = '0;
    logic [31:0] s_rd_data = '0;
    logic        s_rdy_ = 1'b1;
    logic        m0_grnt_, m0_rdy_, m1_grnt_, m1_rdy_;
    logic [31:0] m0_rd_data, m1_rd_data;
    logic        s_as_, s_rw, bus_err;
    logic [29:0] s_addr;
    logic [31:0] s_wr_data;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .reset(reset),
        .m0_req_(m0_req_), .m0_grnt_(m0_grnt_), .m0_as_(m0_as_), .m0_rw(m0_rw),
        .m0_addr(m0_addr), .m0_wr_data(m0_wr_data), .m0_rd_data(m0_rd_data), .m0_rdy_(m0_rdy_),
        .m1_req_(m1_req_), .m1_grnt_(m1_grnt_), .m1_as_(m1_as_), .m1_rw(m1_rw),
        .m1_addr(m1_addr), .m1_wr_data(m1_wr_data), .m1_rd_data(m1_rd_data), .m1_rdy_(m1_rdy_),
        .s_as_(s_as_), .s_rw(s_rw), .s_addr(s_addr), .s_wr_data(s_wr_data),
        .s_rd_data(s_rd_data), .s_rdy_(s_rdy_), .bus_err(bus_err)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Owner is -1 (nobody), 0 or 1; decisions follow the arbitration rules.
    int m_owner = -1;
    bit m_last = 1'b1;
    int m_wait = 0;
    bit chk_en = 1'b0;

    function automatic logic exp_s_as();
        if (m_owner == 0) return m0_as_;
        if (m_owner == 1) return m1_as_;
        return 1'b1;
    endfunction

    function automatic bit m_fire();
`ifdef MEM_BUS_TIMEOUT_EN
        return (m_owner >= 0) && (exp_s_as() == 1'b0) && (s_rdy_ == 1'b1) &&
               (m_wait == TIMEOUT_CYC - 1);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin : model
        int nxt;
        bit r0, r1, fire;
        r0 = !m0_req_;
        r1 = !m1_req_;
        fire = m_fire();
        if (reset) begin
            m_owner = -1;
            m_last  = 1'b1;
            m_wait  = 0;
        end else begin
            if (m_owner < 0) begin
                if (r0 && r1) nxt = m_last ? 0 : 1;
                else if (r0)  nxt = 0;
                else if (r1)  nxt = 1;
                else          nxt = -1;
            end else begin
                bit own_req, oth_req;
                own_req = (m_owner == 0) ? r0 : r1;
                oth_req = (m_owner == 0) ? r1 : r0;
                if (own_req)      nxt = m_owner;
                else if (oth_req) nxt = 1 - m_owner;
                else              nxt = -1;
            end
            if (m_owner < 0 || !s_rdy_ || nxt != m_owner || fire) m_wait = 0;
            else if (exp_s_as() == 1'b0) m_wait++;
            if (nxt >= 0 && nxt != m_owner) m_last = (nxt == 1);
            m_owner = nxt;
        end
    end

    always @(negedge clk) begin : model_check
        bit f;
        if (chk_en) begin
            f = m_fire();
            chk("m0_grnt_", m0_grnt_, m_owner != 0);
            chk("m1_grnt_", m1_grnt_, m_owner != 1);
            chk("s_as_", s_as_, exp_s_as());
            chk("s_rw", s_rw, m_owner == 0 ? m0_rw : m_owner == 1 ? m1_rw : 1'b1);
            chk("s_addr", s_addr, m_owner == 0 ? m0_addr : m_owner == 1 ? m1_addr : 30'd0);
            chk("s_wr_data", s_wr_data, m_owner == 0 ? m0_wr_data : m_owner == 1 ? m1_wr_data : 32'd0);
            chk("m0_rdy_", m0_rdy_, m_owner == 0 ? (f ? 1'b0 : s_rdy_) : 1'b1);
            chk("m0_rd_data", m0_rd_data, (m_owner == 0 && !f) ? s_rd_data : 32'd0);
            chk("m1_rdy_", m1_rdy_, m_owner == 1 ? (f ? 1'b0 : s_rdy_) : 1'b1);
            chk("m1_rd_data", m1_rd_data, (m_owner == 1 && !f) ? s_rd_data : 32'd0);
            chk("bus_err", bus_err, f);
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, r0, r1, a0, a1, w0, w1;
        logic [29:0] ad0, ad1;
        logic        srdy;
        logic [31:0] srd;
        logic        g0, g1, sas, srw;
        logic [29:0] sad;
        logic        m0r;
        logic [31:0] m0d;
        logic        m1r;
        logic [31:0] m1d;
    } vec_t;

    function automatic vec_t mk(input logic rst, r0, r1, a0, a1, w0, w1,
                                input logic [29:0] ad0, ad1, input logic srdy,
                                input logic [31:0] srd, input logic g0, g1, sas, srw,
                                input logic [29:0] sad, input logic m0r,
                                input logic [31:0] m0d, input logic m1r,
                                input logic [31:0] m1d);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
        v.ad0 = ad0; v.ad1 = ad1; v.srdy = srdy; v.srd = srd;
        v.g0 = g0; v.g1 = g1; v.sas = sas; v.srw = srw; v.sad = sad;
        v.m0r = m0r; v.m0d = m0d; v.m1r = m1r; v.m1d = m1d;
        return v;
    endfunction

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        m0_req_ = 1'b1; m0_as_ = 1'b1; m0_rw = 1'b1; m0_addr = '0;
        m1_req_ = 1'b1; m1_as_ = 1'b1; m1_rw = 1'b1; m1_addr = '0;
        s_rdy_ = 1'b1; s_rd_data = '0;
    endtask

    initial begin
        int owner, first, pulses, badrd, ncyc;

        //        rst r0 r1 a0 a1 w0 w1 ad0   ad1   srdy srd            g0 g1 sas srw sad   m0r m0d           m1r m1d
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 1, 0,    0,    1, 0,            1, 1, 1, 1, 0,    1, 0,            1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1, 0,    0,    1, 0,            1, 1, 1, 1, 0,    1, 0,            1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 1, 0,    0,    1, 0,            1, 1, 1, 1, 0,    1, 0,            1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, 'h10, 0,    1, 0,            0, 1, 0, 1, 'h10, 1, 0,            1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, 'h10, 0,    1, 'h55,         0, 1, 0, 1, 'h10, 1, 'h55,         1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, 'h10, 0,    0, 'hDEADBEEF,   0, 1, 0, 1, 'h10, 0, 'hDEADBEEF,   1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1, 'h10, 0,    1, 0,            0, 1, 1, 1, 'h10, 1, 0,            1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1, 0,    0,    1, 0,            1, 1, 1, 1, 0,    1, 0,            1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 1, 1, 0,    0,    1, 0,            1, 1, 1, 1, 0,    1, 0,            1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 'h3,  'h20, 1, 0,            1, 0, 0, 1, 'h20, 1, 0,            1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 'h3,  'h20, 0, 'h12345678,   1, 0, 0, 1, 'h20, 1, 0,            0, 'h12345678));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1, 0,    0,    1, 0,            1, 0, 1, 1, 0,    1, 0,            1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1, 0,    0,    1, 0,            1, 1, 1, 1, 0,    1, 0,            1, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 1, 0,    0,    1, 0,            1, 1, 1, 1, 0,    1, 0,            1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0,    0,    1, 0,            1, 1, 1, 1, 0,    1, 0,            1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 'h40, 0,    0, 'hCAFEF00D,   0, 1, 0, 1, 'h40, 0, 'hCAFEF00D,   1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 1, 1, 0,    0,    1, 0,            0, 1, 1, 1, 0,    1, 0,            1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 1, 1, 0,    0,    1, 0,            1, 0, 1, 1, 0,    1, 0,            1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 1, 0,    'h50, 1, 0,            1, 0, 0, 1, 'h50, 1, 0,            1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 1, 0,    'h50, 1, 0,            1, 1, 1, 1, 0,    1, 0,            1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 1, 0,    'h50, 1, 0,            1, 0, 0, 1, 'h50, 1, 0,            1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1, 0,    0,    1, 0,            1, 0, 1, 1, 0,    1, 0,            1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 1, 0,    0,    1, 0,            1, 1, 1, 1, 0,    1, 0,            1, 0));

        m0_wr_data = 32'hA0A0A0A0;
        m1_wr_data = 32'hB1B1B1B1;
        tick();
        chk_en = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst;
            m0_req_ = tbl[i].r0; m1_req_ = tbl[i].r1;
            m0_as_ = tbl[i].a0; m1_as_ = tbl[i].a1;
            m0_rw = tbl[i].w0; m1_rw = tbl[i].w1;
            m0_addr = tbl[i].ad0; m1_addr = tbl[i].ad1;
            s_rdy_ = tbl[i].srdy; s_rd_data = tbl[i].srd;
            @(negedge clk);
            chk($sformatf("row%0d.m0_grnt_", i), m0_grnt_, tbl[i].g0);
            chk($sformatf("row%0d.m1_grnt_", i), m1_grnt_, tbl[i].g1);
            chk($sformatf("row%0d.s_as_", i), s_as_, tbl[i].sas);
            chk($sformatf("row%0d.s_rw", i), s_rw, tbl[i].srw);
            chk($sformatf("row%0d.s_addr", i), s_addr, tbl[i].sad);
            chk($sformatf("row%0d.m0_rdy_", i), m0_rdy_, tbl[i].m0r);
            chk($sformatf("row%0d.m0_rd_data", i), m0_rd_data, tbl[i].m0d);
            chk($sformatf("row%0d.m1_rdy_", i), m1_rdy_, tbl[i].m1r);
            chk($sformatf("row%0d.m1_rd_data", i), m1_rd_data, tbl[i].m1d);
            tick();
        end

        // Both masters keep requesting, each releasing after one access:
        // ownership must alternate 0,1,0,1,...
        drive_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m0_req_ = 1'b0;
        m1_req_ = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            #1;
            owner = !m0_grnt_ ? 0 : (!m1_grnt_ ? 1 : 2);
            chk($sformatf("alt_owner%0d", k), owner, k % 2);
            if (owner == 0) m0_as_ = 1'b0; else m1_as_ = 1'b0;
            s_rdy_ = 1'b0;
            tick();
            if (owner == 0) begin m0_as_ = 1'b1; m0_req_ = 1'b1; end
            else begin m1_as_ = 1'b1; m1_req_ = 1'b1; end
            s_rdy_ = 1'b1;
            tick();
            if (owner == 0) m0_req_ = 1'b0; else m1_req_ = 1'b0;
        end

        // Owner stalled on s_rdy_=1.
        drive_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m0_req_ = 1'b0;
        tick();
        m0_as_ = 1'b0;
        m0_rw = READ;
        m0_addr = 30'h77;
        s_rd_data = 32'h5A5A5A5A;
        first = 0; pulses = 0; badrd = 0;
`ifdef MEM_BUS_TIMEOUT_EN
        ncyc = TIMEOUT_CYC + 4;
`else
        ncyc = 100;
`endif
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (!m0_rdy_ && first == 0) first = i;
            if (bus_err) begin
                pulses++;
                if (m0_rd_data != 32'd0) badrd++;
            end
            tick();
        end
`ifdef MEM_BUS_TIMEOUT_EN
        chk("timeout_cycle", first, TIMEOUT_CYC);
        chk("timeout_pulses", pulses, 1);
        chk("timeout_rd_data", badrd, 0);
`else
        chk("no_timeout_rdy", first, 0);
        chk("no_timeout_bus_err", pulses, 0);
`endif

        // Randomized traffic against the reference model.
        drive_idle();
        for (int i = 0; i < 800; i++) begin
            tick();
            reset = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 3) == 0) m0_req_ = ~m0_req_;
            if ($urandom_range(0, 3) == 0) m1_req_ = ~m1_req_;
            m0_as_ = $urandom_range(0, 1);
            m1_as_ = $urandom_range(0, 1);
            m0_rw = $urandom_range(0, 1);
            m1_rw = $urandom_range(0, 1);
            m0_addr = 30'($urandom);
            m1_addr = 30'($urandom);
            m0_wr_data = $urandom;
            m1_wr_data = $urandom;
            s_rdy_ = ($urandom_range(0, 2) != 0);
            s_rd_data = $urandom;
        end
        tick();
        @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
